// File: rtl/equalizer_cal_ctrl.sv
// Equalizer calibration sweep controller: steps eq_code through every code, counts
// slicer errors against a reference pattern per code, and settles on the best code.
module equalizer_cal_ctrl #(
  parameter int NUM_CODES     = 8,
  parameter int CODE_W        = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int WINDOW_CYCLES = 64,
  parameter int ERR_W         = $clog2(WINDOW_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              eq_bit,
  input  logic              ref_bit,
  output logic [CODE_W-1:0] eq_code,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  best_errors
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETTLE  = 3'd1;
  localparam logic [2:0] MEASURE = 3'd2;
  localparam logic [2:0] EVAL    = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = ERR_W'(WINDOW_CYCLES);
  localparam logic [CODE_W-1:0] LAST_CODE   = CODE_W'(NUM_CODES - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  phase_cnt;
  logic [ERR_W-1:0]  err_cnt;
  logic [CODE_W-1:0] best_code;
  logic              better;
  logic [CODE_W-1:0] eval_best_code;

  assign busy = (state == SETTLE) || (state == MEASURE) || (state == EVAL);

  // Strict less-than keeps the earlier (lower) code on a tie.
  assign better         = (err_cnt < best_errors);
  assign eval_best_code = better ? eq_code : best_code;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      err_cnt     <= '0;
      eq_code     <= '0;
      best_code   <= '0;
      best_errors <= '1;
      done        <= 1'b0;
    end else if (busy && abort) begin
      // Abort leaves the best code found so far applied; best_errors is kept.
      state   <= IDLE;
      eq_code <= best_code;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= SETTLE;
            phase_cnt   <= '0;
            err_cnt     <= '0;
            eq_code     <= '0;
            best_code   <= '0;
            best_errors <= '1;
            done        <= 1'b0;
          end
        end

        SETTLE: begin
          if (phase_cnt == SETTLE_LAST) begin
            state     <= MEASURE;
            phase_cnt <= '0;
            err_cnt   <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        MEASURE: begin
          if ((eq_bit != ref_bit) && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
          end
          if (phase_cnt == WINDOW_LAST) begin
            state     <= EVAL;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        EVAL: begin
          if (better) begin
            best_errors <= err_cnt;
          end
          best_code <= eval_best_code;
          if (eq_code == LAST_CODE) begin
            state   <= DONE;
            eq_code <= eval_best_code;
            done    <= 1'b1;
          end else begin
            state   <= SETTLE;
            eq_code <= eq_code + CODE_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_equalizer_cal_ctrl.sv
// Self-checking bench for equalizer_cal_ctrl: randomized error injection per code,
// scoreboard of expected sweep results, and directed abort/reset/hold scenarios.
module tb_equalizer_cal_ctrl;

  localparam int S   = 4;
  localparam int W   = 64;
  localparam int P   = S + W + 1;
  localparam int EW  = $clog2(W + 1);
  localparam int ALL_ONES = (1 << EW) - 1;

  typedef int errs_t[8];
  typedef struct {
    int code;
    int errs;
    int start_cyc;
    int lat;
  } exp_t;

  logic clk, rst_n, start, start5, abort, eq_bit, ref_bit;
  logic [2:0]    eq_code, eq_code5;
  logic          busy, done, busy5, done5;
  logic [EW-1:0] best_errors, best_errors5;

  int   n_vec, n_fail, cyc, max5;
  logic done_q, done5_q;
  exp_t sb[$];
  exp_t sb5[$];

  equalizer_cal_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .eq_bit(eq_bit), .ref_bit(ref_bit), .eq_code(eq_code),
    .busy(busy), .done(done), .best_errors(best_errors)
  );

  equalizer_cal_ctrl #(.NUM_CODES(5), .CODE_W(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .abort(1'b0),
    .eq_bit(eq_bit), .ref_bit(ref_bit), .eq_code(eq_code5),
    .busy(busy5), .done(done5), .best_errors(best_errors5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: the winner is the first code holding the minimum count of the
  // codes fully evaluated; with none evaluated, code 0 and an all-ones count.
  function automatic exp_t model(input errs_t errs, input int n, input bit all_bad);
    exp_t r;
    r.code = 0;
    r.errs = ALL_ONES;
    r.start_cyc = 0;
    r.lat = 0;
    for (int k = 0; k < n; k++) begin
      int e;
      e = all_bad ? W : errs[k];
      if (e < r.errs) begin
        r.errs = e;
        r.code = k;
      end
    end
    return r;
  endfunction

  // Scoreboard monitors: compare on each rising edge of done.
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        check("main_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("main_eq_code", 32'(eq_code), e.code);
        check("main_best_errors", 32'(best_errors), e.errs);
        check("main_latency", cyc - e.start_cyc, e.lat);
      end
    end
    done_q = done;
  end

  always @(negedge clk) begin
    if (busy5 && (int'(eq_code5) > max5)) max5 = int'(eq_code5);
    if (done5 && !done5_q) begin
      if (sb5.size() == 0) begin
        check("n5_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb5.pop_front();
        check("n5_eq_code", 32'(eq_code5), e.code);
        check("n5_best_errors", 32'(best_errors5), e.errs);
        check("n5_latency", cyc - e.start_cyc, e.lat);
      end
    end
    done5_q = done5;
  end

  // Drives one sweep from a point just after a rising edge. noise: 0 none,
  // 1 random, 2 always -- applied only outside the measurement window.
  task automatic run_sweep(input bit use5, input errs_t errs, input int ncodes, input int noise,
                           input bit all_bad, input int abort_edge, input bit extra_start);
    logic [W-1:0] mask[8];
    int st, k, p, cnt;
    bit mis;
    exp_t e;
    for (int c = 0; c < 8; c++) begin
      mask[c] = '0;
      cnt = 0;
      while (cnt < errs[c]) begin
        int b;
        b = $urandom_range(W - 1);
        if (!mask[c][b]) begin
          mask[c][b] = 1'b1;
          cnt++;
        end
      end
    end
    if (use5) start5 = 1'b1;
    else start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start5 = 1'b0;
    st = cyc;
    check("start_busy", use5 ? busy5 : busy, 1);
    check("start_done_clr", use5 ? done5 : done, 0);
    check("start_code0", use5 ? 32'(eq_code5) : 32'(eq_code), 0);
    if (abort_edge == 0) begin
      e = model(errs, ncodes, all_bad);
      e.start_cyc = st;
      e.lat = ncodes * P;
      if (use5) sb5.push_back(e);
      else sb.push_back(e);
    end
    for (int j = 1; j <= ncodes * P; j++) begin
      k = (j - 1) / P;
      p = (j - 1) % P;
      if (all_bad) mis = 1'b1;
      else if (p >= S && p < S + W) mis = mask[k][p - S];
      else mis = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(1)) : 1'b0;
      ref_bit = 1'($urandom_range(1));
      eq_bit  = ref_bit ^ mis;
      start   = extra_start && (j % 50 == 0);
      if (j == abort_edge) begin
        abort = 1'b1;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (j == abort_edge) break;
    end
    eq_bit = 1'b0;
    ref_bit = 1'b0;
  endtask

  task automatic abort_case(input errs_t errs, input int abort_edge);
    exp_t e;
    run_sweep(1'b0, errs, 8, 0, 1'b0, abort_edge, 1'b0);
    e = model(errs, (abort_edge - 1) / P, 1'b0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_eq_code", 32'(eq_code), e.code);
    check("abort_best_errors", 32'(best_errors), e.errs);
    repeat (3) @(posedge clk);
    #1;
    check("abort_stays_idle", busy, 0);
  endtask

  initial begin
    errs_t er;
    n_vec = 0;
    n_fail = 0;
    max5 = 0;
    done_q = 1'b0;
    done5_q = 1'b0;
    start = 1'b0;
    start5 = 1'b0;
    abort = 1'b0;
    eq_bit = 1'b0;
    ref_bit = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_eq_code", 32'(eq_code), 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_best_errors", 32'(best_errors), ALL_ONES);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reference sweep with fixed error profile.
    run_sweep(1'b0, '{9, 7, 3, 5, 3, 8, 12, 20}, 8, 0, 1'b0, 0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("hold_done", done, 1);
    check("hold_eq_code", 32'(eq_code), 2);
    check("hold_best_errors", 32'(best_errors), 3);
    check("hold_not_busy", busy, 0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_in_done_done", done, 1);
    check("abort_in_done_code", 32'(eq_code), 2);

    // Error-free window, errors only outside it, repeated start mid-sweep.
    run_sweep(1'b0, '{0, 0, 0, 0, 0, 0, 0, 0}, 8, 2, 1'b0, 0, 1'b1);
    // Permanent mismatch: counter saturates at the window length.
    run_sweep(1'b0, '{0, 0, 0, 0, 0, 0, 0, 0}, 8, 0, 1'b1, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) er[c] = (r < 2) ? $urandom_range(W) : $urandom_range(4);
      run_sweep(1'b0, er, 8, 1, 1'b0, 0, 1'b0);
    end

    // Abort in the second code's measurement window, then in the third.
    abort_case('{10, 30, 1, 1, 1, 1, 1, 1}, P + S + 20);
    abort_case('{10, 4, 2, 1, 1, 1, 1, 1}, 2 * P + S + 10);

    // Asynchronous reset mid-sweep.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    check("amid_rst_busy", busy, 0);
    check("amid_rst_done", done, 0);
    check("amid_rst_eq_code", 32'(eq_code), 0);
    check("amid_rst_best_errors", 32'(best_errors), ALL_ONES);
    #7 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_idle", busy, 0);
    for (int c = 0; c < 8; c++) er[c] = $urandom_range(W);
    run_sweep(1'b0, er, 8, 1, 1'b0, 0, 1'b0);

    // Non-power-of-two code count.
    max5 = 0;
    run_sweep(1'b1, '{20, 15, 12, 9, 2, 0, 0, 0}, 5, 1, 1'b0, 0, 1'b0);
    for (int c = 0; c < 8; c++) er[c] = $urandom_range(8);
    run_sweep(1'b1, er, 5, 0, 1'b0, 0, 1'b0);
    check("n5_max_code", max5, 4);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    check("sb5_drained", sb5.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/equalizer_cal_ctrl.md
EQUALIZER_CAL_CTRL -- requirements
Module: equalizer_cal_ctrl

Interface
REQ-001 Parameter NUM_CODES, default 8: number of equalizer coefficient codes swept (2..256).
REQ-002 Parameter CODE_W, default 3: width of eq_code; 2^CODE_W SHALL be >= NUM_CODES.
REQ-003 Parameter SETTLE_CYCLES, default 4: cycles ignored after each code change (>=1).
REQ-004 Parameter WINDOW_CYCLES, default 64: cycles of error counting per code (>=1).
REQ-005 Parameter ERR_W, derived as clog2(WINDOW_CYCLES+1): width of error counts.
REQ-006 clk  input  1  single clock; all state updates on posedge clk.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  one-cycle request to begin a calibration sweep.
REQ-009 abort  input  1  terminate the sweep in progress.
REQ-010 eq_bit  input  1  sliced equalizer output bit.
REQ-011 ref_bit  input  1  expected (reference pattern) bit, aligned with eq_bit.
REQ-012 eq_code  output  CODE_W  coefficient code driving the equalizer.
REQ-013 busy  output  1  high while a sweep is in progress.
REQ-014 done  output  1  high when a sweep completed and eq_code holds the best code.
REQ-015 best_errors  output  ERR_W  lowest error count found in the last or current sweep.

Function
REQ-016 The FSM SHALL have states IDLE, SETTLE, MEASURE, EVAL, DONE; busy=1 exactly in SETTLE, MEASURE and EVAL.
REQ-017 In IDLE or DONE, start=1 at a clock edge SHALL: eq_code<=0, best_errors<=all ones, best code<=0, done<=0, enter SETTLE.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, with no comparisons counted, then go to MEASURE with the error counter cleared.
REQ-020 MEASURE SHALL last exactly WINDOW_CYCLES cycles; at each of these edges the error counter SHALL increment by 1 when eq_bit != ref_bit.
REQ-021 EVAL SHALL last one cycle: if the error count < best_errors (strict), then best_errors<=count and best code<=eq_code; ties SHALL keep the lower code.
REQ-022 From EVAL: if eq_code == NUM_CODES-1, go to DONE with eq_code<=best code and done<=1; otherwise eq_code<=eq_code+1 and go to SETTLE.
REQ-023 The sweep SHALL take NUM_CODES*(SETTLE_CYCLES+WINDOW_CYCLES+1) cycles: done rises that many edges after the start edge (552 at defaults).
REQ-024 In DONE, eq_code, best_errors and done=1 SHALL hold until start or reset.
REQ-025 abort=1 while busy SHALL, at that edge: enter IDLE, eq_code<=best code so far (0 if no EVAL completed), done<=0, keep best_errors.
REQ-026 abort together with start while busy SHALL be treated as abort only; abort in IDLE or DONE SHALL have no effect.
REQ-027 The error counter SHALL be ERR_W bits wide and SHALL NOT wrap; the maximum count is WINDOW_CYCLES.
REQ-028 The eq_code increment SHALL never exceed NUM_CODES-1, including for non-power-of-two NUM_CODES.

Reset
REQ-029 While rst_n=0 the block SHALL immediately force: state IDLE, eq_code=0, busy=0, done=0, best_errors=all ones, all counters cleared.
REQ-030 Reset asserted mid-sweep SHALL discard all sweep results; after release the block SHALL wait in IDLE for start.

Verification
REQ-031 Defaults; ref_bit=eq_bit except for errors injected per code {9,7,3,5,3,8,12,20} -> done at start+552 cycles, eq_code=2, best_errors=3.
REQ-032 All codes error-free -> eq_code=0, best_errors=0; errors injected only in SETTLE cycles -> no counts recorded.
REQ-033 eq_bit constantly != ref_bit -> best_errors=64, eq_code=0; counter does not wrap.
REQ-034 abort in the 2nd MEASURE after code 0 scored 10 -> next cycle IDLE, busy=0, done=0, eq_code=0, best_errors=10; repeated start mid-sweep ignored.
REQ-035 rst_n pulsed low mid-sweep, asynchronously to clk -> outputs reset immediately; a new start gives a full 552-cycle sweep.
REQ-036 NUM_CODES=5, CODE_W=3 -> eq_code visits 0..4 only; the sweep takes 5*69=345 cycles.
